rf_bank_operand_collector: RTL and testbench
============================================

Name: rf_bank_operand_collector

Overview:
- Sequences banked register-file reads for one issued instruction with up to three source operands.
- The register file has one read port per bank, so operands that map to the same bank are serialized over successive cycles. Identical reads are merged into one.
- Collected operands are presented to the execute stage over a valid/ready handshake.
- Sits between the read stage and execute. It stalls issue upstream while collecting.

Parameters:
- DataWidth, 32, operand and register-file data width.
- TotalNumBank, 8, number of register-file banks; bank enables are one-hot over this width.
- AddrWidth, 5, register address width within a bank.
- TagWidth, 8, width of the opaque instruction tag passed through.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- issue_valid  input  1  instruction with operand requests offered.
- issue_ready  output  1  collector can accept an instruction this cycle.
- issue_tag  input  TagWidth  tag, returned with the operands.
- readEn1, readEn2, readEn3  input  TotalNumBank  one-hot bank select per operand; zero means the operand is unused.
- readAddr1, readAddr2, readAddr3  input  AddrWidth  register address within the selected bank.
- flush  input  1  synchronous abort of the current instruction.
- bank_rd_en  output  TotalNumBank  per-bank read-port enable.
- bank_rd_addr  output  TotalNumBank*AddrWidth  per-bank read address; slice b belongs to bank b.
- bank_rd_data  input  TotalNumBank*DataWidth  per-bank read data, valid exactly one cycle after the matching bank_rd_en.
- out_valid  output  1  operands complete.
- out_ready  input  1  execute accepts the operands.
- out_tag  output  TagWidth  tag of the collected instruction.
- op1, op2, op3  output  DataWidth  collected operands.
- conflict_cycles  output  16  saturating count of extra read rounds caused by bank conflicts.

Behaviour:
- Reset (async): state IDLE; pending and in-flight masks cleared.
  - issue_ready=1, out_valid=0, bank_rd_en=0, bank_rd_addr=0.
  - op1, op2, op3, out_tag, conflict_cycles = 0.
- States: IDLE, READ, DONE.
- issue_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept (issue_valid & issue_ready):
  - Latch tag, addresses and enables.
  - pending[i] = (readEn_i != 0).
  - Operands with readEn_i == 0 are zeroed.
  - Go to READ.
  - If all three are unused, go directly to DONE.
- A multi-hot enable is an illegal input. The lowest set bit is used.
- READ, each cycle:
  - Grant pending operands in priority order 1, 2, 3. An operand is granted if its bank is not yet claimed this cycle.
  - It is also granted if its bank is claimed by the same address; that read is merged and serves both operands.
  - Granted operands drive bank_rd_en and bank_rd_addr combinationally, clear from pending, and register as in-flight.
- The cycle after a grant, bank_rd_data for each in-flight operand is captured into op_i at the clock edge.
- Issue of the next round overlaps with that capture.
- Exit from READ: when pending and in-flight are both empty after a capture edge, go to DONE with out_valid=1.
- Latency:
  - No conflict: out_valid rises 2 cycles after the accept edge.
  - Each extra round adds 1 cycle. The maximum is 4 cycles, for three operands on one bank at distinct addresses.
- conflict_cycles: increments by 1 in each READ cycle where pending is non-empty after granting. It saturates at 16'hFFFF.
- DONE:
  - out_valid, op1..op3 and out_tag are held stable until out_ready.
  - On out_valid & out_ready:
    - With a new accept in the same cycle, go to READ.
    - Otherwise go to IDLE and drop out_valid.
- flush (synchronous, wins over all other events):
  - Clear pending and in-flight and go to IDLE; out_valid=0.
  - Read data returning the cycle after the flush is ignored.
  - An accept in the same cycle as flush is discarded.
- bank_rd_en is 0 in IDLE and DONE.
- rst asserted mid-operation returns immediately to reset values. No partial operand is ever presented.

Test Plan:
- Conflict-free read:
  - Stimulus: readEn1=8'h01/addr 3, readEn2=8'h02/addr 4, readEn3=8'h04/addr 5; RF returns 0xA3, 0xB4, 0xC5.
  - Response: one read round with bank_rd_en=8'h07; out_valid 2 cycles after accept; op1..op3 = 0xA3, 0xB4, 0xC5; conflict_cycles=0.
- Full bank conflict:
  - Stimulus: all three operands on bank 8'h10 at addrs 1, 2, 3.
  - Response: three successive rounds with bank_rd_addr[bank4] = 1, 2, 3; out_valid at cycle 4; conflict_cycles=2.
- Merge:
  - Stimulus: op1 and op3 both on bank 8'h01 addr 7; op2 unused.
  - Response: single round; op1 = op3 = RF value; op2 = 0; latency 2.
- Back-pressure and back-to-back:
  - Stimulus: hold out_ready=0 for 5 cycles, then assert it with issue_valid=1.
  - Response: outputs stable while held; accept occurs in the out_ready cycle; next instruction enters READ without an IDLE gap.
- Flush mid-round:
  - Stimulus: 3-way conflict, flush in the second round.
  - Response: IDLE next cycle; out_valid never asserted; the following instruction's operands are uncorrupted.
- Async reset:
  - Stimulus: assert rst during READ, off a clock edge.
  - Response: bank_rd_en=0, out_valid=0, issue_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rf_bank_operand_collector.sv
// rtl/rf_bank_operand_collector.sv - banked register-file operand collector for one issued instruction
//   clk, rst                  : clock; asynchronous active-high reset
//   issue_valid/ready/tag     : instruction offer with up to three operand requests
//   readEn1..3, readAddr1..3  : one-hot bank select (0 = unused) and in-bank address per operand
//   flush                     : synchronous abort of the current instruction
//   bank_rd_en/addr/data      : per-bank read port; data returns one cycle after the enable
//   out_valid/ready/tag       : collected operands handed to execute
//   op1..op3                  : collected operand values
//   conflict_cycles           : saturating count of extra read rounds caused by bank conflicts
module rf_bank_operand_collector #(
   parameter int DataWidth    = 32,
   parameter int TotalNumBank = 8,
   parameter int AddrWidth    = 5,
   parameter int TagWidth     = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              issue_valid,
   output logic                              issue_ready,
   input  logic [TagWidth-1:0]               issue_tag,
   input  logic [TotalNumBank-1:0]           readEn1,
   input  logic [TotalNumBank-1:0]           readEn2,
   input  logic [TotalNumBank-1:0]           readEn3,
   input  logic [AddrWidth-1:0]              readAddr1,
   input  logic [AddrWidth-1:0]              readAddr2,
   input  logic [AddrWidth-1:0]              readAddr3,
   input  logic                              flush,
   output logic [TotalNumBank-1:0]           bank_rd_en,
   output logic [TotalNumBank*AddrWidth-1:0] bank_rd_addr,
   input  logic [TotalNumBank*DataWidth-1:0] bank_rd_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [TagWidth-1:0]               out_tag,
   output logic [DataWidth-1:0]              op1,
   output logic [DataWidth-1:0]              op2,
   output logic [DataWidth-1:0]              op3,
   output logic [15:0]                       conflict_cycles
);
   localparam int BankIdxW = (TotalNumBank > 1) ? $clog2(TotalNumBank) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                              state_q, state_d;
   logic [2:0]                          pend_q, pend_d;
   logic [2:0]                          infl_q, infl_d;
   logic [2:0][BankIdxW-1:0]            bank_q, bank_d;
   logic [2:0][AddrWidth-1:0]           addr_q, addr_d;
   logic [TagWidth-1:0]                 tag_q, tag_d;
   logic [2:0][DataWidth-1:0]           op_q, op_d;
   logic [15:0]                         conf_q, conf_d;

   logic [2:0][TotalNumBank-1:0]        en_in;
   logic [2:0][AddrWidth-1:0]           addr_in;
   logic [2:0]                          grant;
   logic [TotalNumBank-1:0]             claim_v;
   logic [TotalNumBank-1:0][AddrWidth-1:0] claim_a;
   logic                                accept;

   assign en_in   = {readEn3, readEn2, readEn1};
   assign addr_in = {readAddr3, readAddr2, readAddr1};

   // Multi-hot selects are illegal; the lowest set bit picks the bank.
   function automatic logic [BankIdxW-1:0] lowest_bank(input logic [TotalNumBank-1:0] en);
      lowest_bank = '0;
      for (int b = TotalNumBank - 1; b >= 0; b--) begin
         if (en[b]) lowest_bank = BankIdxW'(b);
      end
   endfunction

   // One read port per bank: grant pending operands in order 1,2,3.
   always_comb begin
      claim_v = '0;
      claim_a = '0;
      grant   = '0;
      if (state_q == READ) begin
         for (int i = 0; i < 3; i++) begin
            if (pend_q[i]) begin
               if (!claim_v[bank_q[i]]) begin
                  claim_v[bank_q[i]] = 1'b1;
                  claim_a[bank_q[i]] = addr_q[i];
                  grant[i]           = 1'b1;
               end else if (claim_a[bank_q[i]] == addr_q[i]) begin
                  // Same register already being read this round: share the read.
                  grant[i] = 1'b1;
               end
            end
         end
      end
   end

   assign bank_rd_en   = claim_v;
   assign bank_rd_addr = claim_a;

   assign issue_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept      = issue_valid && issue_ready;

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q & ~grant;
      infl_d  = grant;
      bank_d  = bank_q;
      addr_d  = addr_q;
      tag_d   = tag_q;
      op_d    = op_q;
      conf_d  = conf_q;

      // Data for last cycle's grants is on the bus now; overlaps the next round's issue.
      for (int i = 0; i < 3; i++) begin
         if (infl_q[i]) begin
            for (int b = 0; b < TotalNumBank; b++) begin
               if (bank_q[i] == BankIdxW'(b)) op_d[i] = bank_rd_data[b*DataWidth +: DataWidth];
            end
         end
      end

      if ((state_q == READ) && ((pend_q & ~grant) != 3'b000) && (conf_q != 16'hFFFF))
         conf_d = conf_q + 16'd1;

      case (state_q)
         READ:    if (pend_q == 3'b000) state_d = DONE;  // final capture happens at this edge
         DONE:    if (out_ready) state_d = IDLE;
         default: ;
      endcase

      if (accept) begin
         tag_d = issue_tag;
         for (int i = 0; i < 3; i++) begin
            pend_d[i] = |en_in[i];
            bank_d[i] = lowest_bank(en_in[i]);
            addr_d[i] = addr_in[i];
            op_d[i]   = '0;
         end
         state_d = (|en_in[0] || |en_in[1] || |en_in[2]) ? READ : DONE;
      end

      // Flush overrides everything, including a same-cycle accept and capture.
      if (flush) begin
         state_d = IDLE;
         pend_d  = '0;
         infl_d  = '0;
         bank_d  = bank_q;
         addr_d  = addr_q;
         tag_d   = tag_q;
         op_d    = op_q;
         conf_d  = conf_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pend_q  <= '0;
         infl_q  <= '0;
         bank_q  <= '0;
         addr_q  <= '0;
         tag_q   <= '0;
         op_q    <= '0;
         conf_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         infl_q  <= infl_d;
         bank_q  <= bank_d;
         addr_q  <= addr_d;
         tag_q   <= tag_d;
         op_q    <= op_d;
         conf_q  <= conf_d;
      end
   end

   assign out_valid       = (state_q == DONE);
   assign out_tag         = tag_q;
   assign op1             = op_q[0];
   assign op2             = op_q[1];
   assign op3             = op_q[2];
   assign conflict_cycles = conf_q;

endmodule

// File: tb/tb_rf_bank_operand_collector.sv
// tb/tb_rf_bank_operand_collector.sv - self-checking bench for rf_bank_operand_collector
module tb_rf_bank_operand_collector;
   localparam int DW = 32;
   localparam int NB = 8;
   localparam int AW = 5;
   localparam int TW = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              issue_valid;
   logic              issue_ready;
   logic [TW-1:0]     issue_tag;
   logic [NB-1:0]     readEn1, readEn2, readEn3;
   logic [AW-1:0]     readAddr1, readAddr2, readAddr3;
   logic              flush;
   logic [NB-1:0]     bank_rd_en;
   logic [NB*AW-1:0]  bank_rd_addr;
   logic [NB*DW-1:0]  bank_rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [TW-1:0]     out_tag;
   logic [DW-1:0]     op1, op2, op3;
   logic [15:0]       conflict_cycles;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] rf [NB][1<<AW];

   always #5 clk = ~clk;

   rf_bank_operand_collector #(
      .DataWidth(DW), .TotalNumBank(NB), .AddrWidth(AW), .TagWidth(TW)
   ) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
      .readEn1(readEn1), .readEn2(readEn2), .readEn3(readEn3),
      .readAddr1(readAddr1), .readAddr2(readAddr2), .readAddr3(readAddr3),
      .flush(flush),
      .bank_rd_en(bank_rd_en), .bank_rd_addr(bank_rd_addr), .bank_rd_data(bank_rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
      .op1(op1), .op2(op2), .op3(op3),
      .conflict_cycles(conflict_cycles)
   );

   // Register-file banks: data one cycle after the enable, garbage otherwise.
   always @(posedge clk) begin
      for (int b = 0; b < NB; b++)
         bank_rd_data[b*DW +: DW] <= bank_rd_en[b] ? rf[b][bank_rd_addr[b*AW +: AW]] : DW'($urandom);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Whole-instruction schedule: rounds of bank reads, expected operand values.
   typedef struct packed {
      logic [1:0]             r;
      logic [2:0][NB-1:0]     en;
      logic [2:0][NB*AW-1:0]  addr;
      logic [2:0][DW-1:0]     op;
   } plan_t;

   function automatic plan_t make_plan(input logic [NB-1:0] e1, e2, e3,
                                       input logic [AW-1:0] a1, a2, a3);
      plan_t p;
      logic [NB-1:0] e[3];
      logic [AW-1:0] ad[3];
      int bank[3];
      bit left[3];
      int rounds;
      p = '0;
      e[0] = e1; e[1] = e2; e[2] = e3;
      ad[0] = a1; ad[1] = a2; ad[2] = a3;
      for (int i = 0; i < 3; i++) begin
         left[i] = (e[i] != '0);
         bank[i] = 0;
         for (int b = NB - 1; b >= 0; b--) if (e[i][b]) bank[i] = b;
         p.op[i] = left[i] ? rf[bank[i]][ad[i]] : '0;
      end
      rounds = 0;
      while (left[0] || left[1] || left[2]) begin
         for (int i = 0; i < 3; i++) begin
            if (left[i]) begin
               if (!p.en[rounds][bank[i]]) begin
                  p.en[rounds][bank[i]] = 1'b1;
                  p.addr[rounds][bank[i]*AW +: AW] = ad[i];
                  left[i] = 1'b0;
               end else if (p.addr[rounds][bank[i]*AW +: AW] == ad[i]) begin
                  left[i] = 1'b0;
               end
            end
         end
         rounds++;
      end
      p.r = rounds[1:0];
      return p;
   endfunction

   // Model: 0 idle, 1 collecting (m_c cycles since accept), 2 done.
   int          m_state;
   int          m_c;
   plan_t       m_plan;
   plan_t       np;
   logic [TW-1:0] m_tag;
   logic [15:0] m_conf;

   always @(posedge clk or posedge rst) begin
      np = make_plan(readEn1, readEn2, readEn3, readAddr1, readAddr2, readAddr3);
      if (rst) begin
         m_state <= 0;
         m_c     <= 0;
         m_plan  <= '0;
         m_tag   <= '0;
         m_conf  <= '0;
      end else if (flush) begin
         m_state <= 0;
      end else begin
         case (m_state)
            1: begin
               if (m_c < int'(m_plan.r) - 1)
                  m_conf <= (m_conf == 16'hFFFF) ? m_conf : m_conf + 16'd1;
               if (m_c == int'(m_plan.r)) m_state <= 2;
               else m_c <= m_c + 1;
            end
            default: begin
               if (m_state == 0 || out_ready) begin
                  if (issue_valid) begin
                     m_plan  <= np;
                     m_tag   <= issue_tag;
                     m_c     <= 0;
                     m_state <= (np.r == 2'd0) ? 2 : 1;
                  end else begin
                     m_state <= 0;
                  end
               end
            end
         endcase
      end
   end

   always @(negedge clk) begin
      logic [NB-1:0]    e_en;
      logic [NB*AW-1:0] e_addr;
      e_en   = '0;
      e_addr = '0;
      if (m_state == 1 && m_c < int'(m_plan.r)) begin
         e_en   = m_plan.en[m_c];
         e_addr = m_plan.addr[m_c];
      end
      chk("issue_ready", issue_ready, (m_state == 0) || (m_state == 2 && out_ready));
      chk("out_valid", out_valid, m_state == 2);
      chk("bank_rd_en", bank_rd_en, e_en);
      chk("bank_rd_addr", bank_rd_addr, e_addr);
      chk("conflict_cycles", conflict_cycles, m_conf);
      if (m_state == 2) begin
         chk("out_tag", out_tag, m_tag);
         chk("op1", op1, m_plan.op[0]);
         chk("op2", op2, m_plan.op[1]);
         chk("op3", op3, m_plan.op[2]);
      end
   end

   task automatic issue(input logic [NB-1:0] e1, input logic [AW-1:0] a1,
                        input logic [NB-1:0] e2, input logic [AW-1:0] a2,
                        input logic [NB-1:0] e3, input logic [AW-1:0] a3,
                        input logic [TW-1:0] tag);
      int n;
      bit ok;
      n = 0;
      ok = 1'b0;
      readEn1 = e1; readAddr1 = a1;
      readEn2 = e2; readAddr2 = a2;
      readEn3 = e3; readAddr3 = a3;
      issue_tag = tag;
      issue_valid = 1'b1;
      while (!ok && n < 50) begin
         @(negedge clk);
         ok = issue_ready && !flush;
         @(posedge clk);
         #1;
         n++;
      end
      issue_valid = 1'b0;
      chk("issue_accept", ok, 1);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!out_valid && lat < 20);
   endtask

   function automatic logic [NB-1:0] rand_en();
      int r;
      logic [NB-1:0] one;
      one = 1;
      r = $urandom_range(0, 15);
      if (r < 4) return '0;
      if (r == 15) return NB'($urandom) | (one << $urandom_range(0, NB-1));
      return one << $urandom_range(0, NB-1);
   endfunction

   initial begin
      int lat;
      logic [15:0] c0;
      rst = 1'b1;
      issue_valid = 1'b0; issue_tag = '0; flush = 1'b0; out_ready = 1'b1;
      readEn1 = '0; readEn2 = '0; readEn3 = '0;
      readAddr1 = '0; readAddr2 = '0; readAddr3 = '0;
      for (int b = 0; b < NB; b++)
         for (int a = 0; a < (1<<AW); a++) rf[b][a] = $urandom;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_issue_ready", issue_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_bank_rd_en", bank_rd_en, 0);
      chk("rst_bank_rd_addr", bank_rd_addr, 0);
      chk("rst_op1", op1, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_conflict", conflict_cycles, 0);

      // Conflict-free
      rf[0][3] = 32'hA3; rf[1][4] = 32'hB4; rf[2][5] = 32'hC5;
      issue(8'h01, 5'd3, 8'h02, 5'd4, 8'h04, 5'd5, 8'h11);
      chk("t1_en", bank_rd_en, 8'h07);
      wait_valid(lat);
      chk("t1_latency", lat, 2);
      chk("t1_op1", op1, 32'hA3);
      chk("t1_op2", op2, 32'hB4);
      chk("t1_op3", op3, 32'hC5);
      chk("t1_conflict", conflict_cycles, 0);

      // Full bank conflict on bank 4
      rf[4][1] = 32'h41; rf[4][2] = 32'h42; rf[4][3] = 32'h43;
      c0 = conflict_cycles;
      issue(8'h10, 5'd1, 8'h10, 5'd2, 8'h10, 5'd3, 8'h22);
      chk("model_rounds", m_plan.r, 3);
      for (int k = 0; k < 3; k++) begin
         chk("t2_en", bank_rd_en, 8'h10);
         chk("t2_addr", bank_rd_addr[24:20], k + 1);
         @(posedge clk);
         #1;
      end
      wait_valid(lat);
      chk("t2_latency", 3 + lat, 4);
      chk("t2_conflict_delta", conflict_cycles - c0, 2);
      chk("t2_op1", op1, 32'h41);
      chk("t2_op2", op2, 32'h42);
      chk("t2_op3", op3, 32'h43);

      // Merge: op1 and op3 read the same register
      rf[0][7] = 32'h0707_1234;
      issue(8'h01, 5'd7, 8'h00, 5'd0, 8'h01, 5'd7, 8'h33);
      chk("t3_en", bank_rd_en, 8'h01);
      chk("model_merge_rounds", m_plan.r, 1);
      wait_valid(lat);
      chk("t3_latency", lat, 2);
      chk("t3_op1", op1, 32'h0707_1234);
      chk("t3_op2", op2, 0);
      chk("t3_op3", op3, 32'h0707_1234);

      // Back-pressure then back-to-back accept
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      rf[5][9] = 32'h5509; rf[6][10] = 32'h6610; rf[7][11] = 32'h7711;
      rf[0][12] = 32'h0012; rf[3][13] = 32'h3313;
      issue(8'h20, 5'd9, 8'h40, 5'd10, 8'h80, 5'd11, 8'h44);
      wait_valid(lat);
      chk("t4_latency", lat, 2);
      issue_valid = 1'b1; issue_tag = 8'h55;
      readEn1 = 8'h01; readAddr1 = 5'd12;
      readEn2 = 8'h08; readAddr2 = 5'd13;
      readEn3 = 8'h00; readAddr3 = 5'd0;
      for (int k = 0; k < 5; k++) begin
         chk("t4_hold_valid", out_valid, 1);
         chk("t4_hold_ready", issue_ready, 0);
         chk("t4_hold_op1", op1, 32'h5509);
         chk("t4_hold_op3", op3, 32'h7711);
         chk("t4_hold_tag", out_tag, 8'h44);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      issue_valid = 1'b0;
      chk("t4_b2b_valid", out_valid, 0);
      chk("t4_b2b_en", bank_rd_en, 8'h09);
      chk("t4_b2b_tag", out_tag, 8'h55);
      wait_valid(lat);
      chk("t4_b2b_latency", lat, 2);
      chk("t4_b2b_op1", op1, 32'h0012);
      chk("t4_b2b_op2", op2, 32'h3313);
      chk("t4_b2b_op3", op3, 0);

      // Flush in the second round of a 3-way conflict
      rf[3][4] = 32'h3004; rf[3][5] = 32'h3005; rf[3][6] = 32'h3006;
      issue(8'h08, 5'd4, 8'h08, 5'd5, 8'h08, 5'd6, 8'h66);
      @(posedge clk);
      #1;
      chk("t5_round2_addr", bank_rd_addr[19:15], 5);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("t5_idle_ready", issue_ready, 1);
      chk("t5_idle_valid", out_valid, 0);
      chk("t5_idle_en", bank_rd_en, 0);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         chk("t5_no_valid", out_valid, 0);
      end
      rf[0][1] = 32'hF001; rf[1][2] = 32'hF102;
      issue(8'h01, 5'd1, 8'h02, 5'd2, 8'h00, 5'd0, 8'h77);
      wait_valid(lat);
      chk("t5_next_latency", lat, 2);
      chk("t5_next_op1", op1, 32'hF001);
      chk("t5_next_op2", op2, 32'hF102);
      chk("t5_next_op3", op3, 0);
      chk("t5_next_tag", out_tag, 8'h77);

      // Asynchronous reset during READ, off the clock edge
      issue(8'h02, 5'd1, 8'h02, 5'd2, 8'h02, 5'd3, 8'h88);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("t6_en", bank_rd_en, 0);
      chk("t6_valid", out_valid, 0);
      chk("t6_ready", issue_ready, 1);
      chk("t6_conflict", conflict_cycles, 0);
      chk("t6_op1", op1, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Randomized traffic against the model
      for (int cyc = 0; cyc < 3000; cyc++) begin
         issue_valid = 1'($urandom_range(0, 1));
         out_ready   = ($urandom_range(0, 9) < 7);
         flush       = ($urandom_range(0, 49) == 0);
         issue_tag   = TW'($urandom);
         readEn1 = rand_en(); readAddr1 = AW'($urandom_range(0, 3));
         readEn2 = rand_en(); readAddr2 = AW'($urandom_range(0, 3));
         readEn3 = rand_en(); readAddr3 = AW'($urandom_range(0, 3));
         @(posedge clk);
         #1;
      end
      issue_valid = 1'b0;
      flush = 1'b0;
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
